pht_update_controller: RTL and testbench
========================================

PHT_UPDATE_CONTROLLER -- requirements
Module: pht_update_controller

Interface
REQ-001 SHALL have parameter PHT_INDEX_WIDTH, default 10, PHT index bits (2^W entries).
REQ-002 SHALL have parameter UPD_FIFO_DEPTH, default 4, update-queue entries; power of two, at least 2.
REQ-003 SHALL have parameter PHT_INIT_VALUE, default 2'b10, counter value written by the init sweep (weakly taken).
REQ-004 SHALL have ports: clk in 1, the single clock; rst in 1, reset, asynchronous active-high.
REQ-005 SHALL have ports: upd_valid in 1, resolved conditional branch; upd_index in W, its PHT index; upd_taken in 1, its outcome; upd_ready out 1, queue can accept.
REQ-006 SHALL have ports: flush_req in 1, one-cycle pulse requesting PHT re-initialisation.
REQ-007 SHALL have ports: pht_rd_index out W; pht_rd_data in 2, combinational read of the external PHT.
REQ-008 SHALL have ports: pht_we out 1; pht_wr_index out W; pht_wr_data out 2. The PHT writes on the clk edge while pht_we is high.
REQ-009 SHALL have ports: init_busy out 1, sweep in progress, fetch forces not-taken; overflow out 1, sticky dropped-update flag.

Function
REQ-010 SHALL implement FSM states INIT and RUN; INIT->RUN after the last sweep write; any state->INIT on flush_req.
REQ-011 INIT SHALL write PHT_INIT_VALUE to index 0..2^W-1, one per cycle, ascending; pht_we=1 every INIT cycle; sweep lasts exactly 2^W cycles.
REQ-012 init_busy SHALL be 1 in every INIT cycle and 0 in RUN.
REQ-013 upd_ready SHALL be the negation of FIFO full, independent of upd_valid (no pop-through).
REQ-014 When upd_valid=1 and upd_ready=1, {upd_index,upd_taken} SHALL be enqueued at the clock edge, in both INIT and RUN.
REQ-015 When upd_valid=1 and upd_ready=0, the update SHALL be discarded and overflow set to 1; overflow clears only on rst.
REQ-016 In RUN with FIFO non-empty and no hazard stall, the head SHALL be popped, with pht_rd_index=head index.
REQ-017 The next counter SHALL saturate: taken gives min(c+1,3); not-taken gives max(c-1,0).
REQ-018 The pop in cycle N SHALL produce registered pht_we=1, pht_wr_index and pht_wr_data in cycle N+1. Throughput is 1 update/cycle.
REQ-019 No pop SHALL occur in INIT; pht_rd_index SHALL equal the FIFO head index (0 when empty).
REQ-020 A simultaneous push and pop SHALL leave occupancy unchanged; FIFO pointers SHALL wrap modulo UPD_FIFO_DEPTH.
REQ-021 flush_req SHALL empty the FIFO, cancel any pending write, drop a same-cycle push and restart the sweep at index 0.
REQ-022 flush_req during INIT SHALL restart the sweep at index 0.

Reset
REQ-023 On rst: state=INIT, sweep index=0, FIFO empty, overflow=0, and the pending write register cleared.
REQ-024 Because state=INIT during rst, init_busy=1, pht_we=1 and pht_wr_data=PHT_INIT_VALUE; upd_ready=1.
REQ-025 Reset mid-update SHALL lose all queued and pending updates.

Configuration
REQ-026 With PHT_UPDATE_FORWARD_EN defined: if the pending write index equals the popped index, the pending pht_wr_data SHALL replace pht_rd_data as the counter source, with no stall.
REQ-027 Without PHT_UPDATE_FORWARD_EN: on that index match the pop SHALL stall one cycle. Throughput for back-to-back same-index updates is 1 per 2 cycles.

Structure
REQ-028 PhtCounter (2-bit), PHT_INIT_VALUE and the PhtUpdateEntry struct {index, taken} SHALL live in PipelineTypes, next to the PHT index type.
REQ-029 The queue SHALL be a sub-module pht_update_fifo (parameterised depth/width, push/pop/full/empty). Saturation logic SHALL be a package function.

Verification (W=4, depth=4)
REQ-030 Init: rst release gives 16 cycles of pht_we with indices 0..15 and data 2'b10, then init_busy=0 in cycle 17.
REQ-031 Saturate: 3 taken updates to index 5 give writes 3,3,3 (starting at 2'b10); 4 not-taken updates give 2,1,0,0.
REQ-032 Hazard: index 7 taken twice back-to-back gives writes 3,3 on consecutive cycles with FORWARD_EN; without it, the second write is 1 cycle later.
REQ-033 Overflow: 6 pushes during INIT give upd_ready=0 after 4 pushes and overflow=1; after INIT, 4 writes drain.
REQ-034 Flush: flush_req with 3 queued updates gives no update write, sweep restarting at index 0, and FIFO empty.
REQ-035 Async reset asserted mid-sweep gives init_busy=1 and sweep index 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/pht_update_controller_pkg.sv
// Shared pipeline types for the PHT update path: the 2-bit counter type,
// its sweep value, the update-queue entry, the controller state encoding
// and the saturating counter helper.
package pht_update_controller_pkg;

   localparam int PHT_INDEX_WIDTH_DEFAULT = 10;

   typedef logic [1:0] pht_counter_t;
   typedef logic [PHT_INDEX_WIDTH_DEFAULT-1:0] pht_index_t;

   // Weakly-taken value written to every entry by the init sweep.
   localparam pht_counter_t PHT_INIT_VALUE_DEFAULT = 2'b10;

   // One resolved branch waiting to be folded into the PHT.
   typedef struct packed {
      pht_index_t index;
      logic       taken;
   } pht_update_entry_t;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } pht_state_e;

   // Two-bit saturating counter step: taken counts up to 3, not-taken down to 0.
   function automatic pht_counter_t pht_sat_update(input pht_counter_t cnt, input logic taken);
      pht_counter_t res;
      if (taken) begin
         res = (cnt == 2'b11) ? cnt : cnt + 2'b01;
      end else begin
         res = (cnt == 2'b00) ? cnt : cnt - 2'b01;
      end
      return res;
   endfunction

endpackage

// File: rtl/pht_update_controller_if.sv
// Bus bundle between the branch-resolution/PHT environment (master) and the
// PHT update controller (slave).
//
// Handshake: an update transfers on a clock edge where upd_valid and
// upd_ready are both high. upd_ready depends only on queue occupancy, never
// on upd_valid. upd_valid high while upd_ready is low drops the update and
// raises the sticky overflow flag. flush_req is a single-cycle pulse with no
// handshake.
interface pht_update_controller_if
   import pht_update_controller_pkg::*;
#(
   parameter int W = 10
);
   logic         upd_valid;
   logic [W-1:0] upd_index;
   logic         upd_taken;
   logic         upd_ready;
   logic         flush_req;
   logic [W-1:0] pht_rd_index;
   pht_counter_t pht_rd_data;
   logic         pht_we;
   logic [W-1:0] pht_wr_index;
   pht_counter_t pht_wr_data;
   logic         init_busy;
   logic         overflow;
   pht_state_e   dbg_state;

   modport master (
      output upd_valid, upd_index, upd_taken, flush_req, pht_rd_data,
      input  upd_ready, pht_rd_index, pht_we, pht_wr_index, pht_wr_data,
             init_busy, overflow, dbg_state
   );

   modport slave (
      input  upd_valid, upd_index, upd_taken, flush_req, pht_rd_data,
      output upd_ready, pht_rd_index, pht_we, pht_wr_index, pht_wr_data,
             init_busy, overflow, dbg_state
   );
endinterface

// File: rtl/pht_update_fifo.sv
// Small circular queue for pending PHT updates. Pushes into a full queue
// and pops from an empty queue are ignored; clear empties it in one cycle.
module pht_update_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign dout    = mem_q[rd_ptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Next storage, pointer and occupancy; pointers wrap naturally (power-of-two depth).
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
      if (do_push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   // Queue state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end
endmodule

// File: rtl/pht_update_controller.sv
// PHT update controller: sweeps the external PHT to the init value after
// reset/flush, then drains queued branch outcomes into saturating counter
// writes at up to one per cycle.
// Build option PHT_UPDATE_FORWARD_EN: forward the in-flight write when the
// next update hits the same index instead of stalling one cycle.
module pht_update_controller
   import pht_update_controller_pkg::*;
#(
   parameter int           PHT_INDEX_WIDTH = 10,
   parameter int           UPD_FIFO_DEPTH  = 4,
   parameter pht_counter_t PHT_INIT_VALUE  = PHT_INIT_VALUE_DEFAULT
) (
   input logic                   clk,
   input logic                   rst,
   pht_update_controller_if.slave bus
);
   localparam int W  = PHT_INDEX_WIDTH;
   localparam int EW = W + 1;

   pht_state_e   state_q, state_d;
   logic [W-1:0] sweep_idx_q, sweep_idx_d;
   logic         overflow_q, overflow_d;
   logic         wr_valid_q, wr_valid_d;
   logic [W-1:0] wr_index_q, wr_index_d;
   pht_counter_t wr_data_q, wr_data_d;

   logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [EW-1:0] fifo_head;
   logic [W-1:0]  head_index;
   logic          head_taken;
   logic          hazard, stall;
   pht_counter_t  ctr_src;

   pht_update_fifo #(
      .DEPTH (UPD_FIFO_DEPTH),
      .WIDTH (EW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clear (bus.flush_req),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   ({bus.upd_index, bus.upd_taken}),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign head_index = fifo_head[EW-1:1];
   assign head_taken = fifo_head[0];

   // The in-flight write targets the entry we are about to read.
   assign hazard = wr_valid_q && !fifo_empty && (wr_index_q == head_index);

`ifdef PHT_UPDATE_FORWARD_EN
   assign stall   = 1'b0;
   assign ctr_src = hazard ? wr_data_q : bus.pht_rd_data;
`else
   assign stall   = hazard;
   assign ctr_src = bus.pht_rd_data;
`endif

   // A flush drops any same-cycle push and blocks the pop; no pops during the sweep.
   assign fifo_push = bus.upd_valid && !fifo_full && !bus.flush_req;
   assign fifo_pop  = (state_q == ST_RUN) && !fifo_empty && !stall && !bus.flush_req;

   // Next-state: sweep progress, pending write capture, sticky overflow, flush restart.
   always_comb begin
      state_d     = state_q;
      sweep_idx_d = sweep_idx_q;
      overflow_d  = overflow_q | (bus.upd_valid & fifo_full);
      wr_valid_d  = fifo_pop;
      wr_index_d  = wr_index_q;
      wr_data_d   = wr_data_q;
      if (fifo_pop) begin
         wr_index_d = head_index;
         wr_data_d  = pht_sat_update(ctr_src, head_taken);
      end
      case (state_q)
         ST_INIT: begin
            if (sweep_idx_q == '1) begin
               state_d     = ST_RUN;
               sweep_idx_d = '0;
            end else begin
               sweep_idx_d = sweep_idx_q + W'(1);
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
      if (bus.flush_req) begin
         state_d     = ST_INIT;
         sweep_idx_d = '0;
         wr_valid_d  = 1'b0;
      end
   end

   // Controller state registers; reset lands in the sweep with nothing pending.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_INIT;
         sweep_idx_q <= '0;
         overflow_q  <= 1'b0;
         wr_valid_q  <= 1'b0;
         wr_index_q  <= '0;
         wr_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         sweep_idx_q <= sweep_idx_d;
         overflow_q  <= overflow_d;
         wr_valid_q  <= wr_valid_d;
         wr_index_q  <= wr_index_d;
         wr_data_q   <= wr_data_d;
      end
   end

   assign bus.init_busy    = (state_q == ST_INIT);
   assign bus.pht_we       = bus.init_busy | wr_valid_q;
   assign bus.pht_wr_index = bus.init_busy ? sweep_idx_q : wr_index_q;
   assign bus.pht_wr_data  = bus.init_busy ? PHT_INIT_VALUE : wr_data_q;
   assign bus.upd_ready    = !fifo_full;
   assign bus.pht_rd_index = fifo_empty ? '0 : head_index;
   assign bus.overflow     = overflow_q;
   assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_pht_update_controller.sv
// Directed bench for pht_update_controller with a 16-entry PHT model and a
// 4-deep update queue. Honours PHT_UPDATE_FORWARD_EN for hazard timing.
module tb_pht_update_controller;
   import pht_update_controller_pkg::*;

   localparam int W = 4;

   typedef struct packed {
      logic [31:0]  cyc;
      logic [W-1:0] idx;
      logic [1:0]   data;
   } wr_rec_t;

   logic clk;
   logic rst;
   int   checks_total;
   int   checks_passed;
   int   cycle;
   logic [1:0] pht_mem [16];
   wr_rec_t obs_q[$];
   wr_rec_t r0, r1;

   pht_update_controller_if #(.W(W)) bus ();

   pht_update_controller #(
      .PHT_INDEX_WIDTH (W),
      .UPD_FIFO_DEPTH  (4),
      .PHT_INIT_VALUE  (2'b10)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Clock and cycle counter.
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   // External PHT: combinational read, write on the edge while pht_we is high.
   assign bus.pht_rd_data = pht_mem[bus.pht_rd_index];
   always @(posedge clk) begin
      if (bus.pht_we) pht_mem[bus.pht_wr_index] <= bus.pht_wr_data;
   end

   // Record update writes (sweep writes excluded), sampled away from the edge.
   always @(negedge clk) begin
      if (!rst && bus.pht_we && !bus.init_busy) begin
         obs_q.push_back('{cyc: cycle, idx: bus.pht_wr_index, data: bus.pht_wr_data});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_total++;
      assert (obs === exp) checks_passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic push(input logic [W-1:0] idx, input logic taken);
      bus.upd_valid = 1'b1;
      bus.upd_index = idx;
      bus.upd_taken = taken;
      step();
      bus.upd_valid = 1'b0;
   endtask

   task automatic flush();
      bus.flush_req = 1'b1;
      step();
      bus.flush_req = 1'b0;
   endtask

   task automatic wait_obs(input string tag, input int n, input int budget);
      for (int i = 0; i < budget && obs_q.size() < n; i++) step();
      check(tag, 32'(obs_q.size()), 32'(n));
   endtask

   task automatic expect_write(input string tag, input logic [W-1:0] idx, input logic [1:0] data);
      if (obs_q.size() == 0) begin
         check({tag, "_present"}, 32'd0, 32'd1);
      end else begin
         r0 = obs_q.pop_front();
         check({tag, "_idx"}, 32'(r0.idx), 32'(idx));
         check({tag, "_data"}, 32'(r0.data), 32'(data));
      end
   endtask

   initial begin
      checks_total  = 0;
      checks_passed = 0;
      cycle         = 0;
      for (int i = 0; i < 16; i++) pht_mem[i] = 2'b00;
      rst           = 1'b1;
      bus.upd_valid = 1'b0;
      bus.upd_index = '0;
      bus.upd_taken = 1'b0;
      bus.flush_req = 1'b0;

      // Reset state.
      step(); step(); step();
      check("rst_init_busy", 32'(bus.init_busy), 32'd1);
      check("rst_we", 32'(bus.pht_we), 32'd1);
      check("rst_wr_data", 32'(bus.pht_wr_data), 32'd2);
      check("rst_wr_index", 32'(bus.pht_wr_index), 32'd0);
      check("rst_ready", 32'(bus.upd_ready), 32'd1);
      check("rst_overflow", 32'(bus.overflow), 32'd0);
      check("rst_state", 32'(bus.dbg_state), 32'(ST_INIT));

      // Init sweep: 16 writes of 2'b10 at ascending indices, then RUN.
      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         check("sweep_we", 32'(bus.pht_we), 32'd1);
         check("sweep_idx", 32'(bus.pht_wr_index), 32'(i));
         check("sweep_data", 32'(bus.pht_wr_data), 32'd2);
         step();
      end
      check("sweep_done_busy", 32'(bus.init_busy), 32'd0);
      check("sweep_done_we", 32'(bus.pht_we), 32'd0);
      check("sweep_done_state", 32'(bus.dbg_state), 32'(ST_RUN));
      check("sweep_mem11", 32'(pht_mem[11]), 32'd2);
      check("run_rd_index_empty", 32'(bus.pht_rd_index), 32'd0);

      // Saturation up: 2 -> 3,3,3.
      push(4'd5, 1'b1); push(4'd5, 1'b1); push(4'd5, 1'b1);
      wait_obs("sat_up_count", 3, 20);
      expect_write("sat_up0", 4'd5, 2'd3);
      expect_write("sat_up1", 4'd5, 2'd3);
      expect_write("sat_up2", 4'd5, 2'd3);

      // Saturation down: 3 -> 2,1,0,0.
      push(4'd5, 1'b0); push(4'd5, 1'b0); push(4'd5, 1'b0); push(4'd5, 1'b0);
      wait_obs("sat_dn_count", 4, 20);
      expect_write("sat_dn0", 4'd5, 2'd2);
      expect_write("sat_dn1", 4'd5, 2'd1);
      expect_write("sat_dn2", 4'd5, 2'd0);
      expect_write("sat_dn3", 4'd5, 2'd0);

      // Same-index back-to-back: write spacing depends on forwarding.
      push(4'd7, 1'b1); push(4'd7, 1'b1);
      wait_obs("haz_count", 2, 20);
      r0 = obs_q.pop_front();
      r1 = obs_q.pop_front();
      check("haz_data0", 32'(r0.data), 32'd3);
      check("haz_data1", 32'(r1.data), 32'd3);
`ifdef PHT_UPDATE_FORWARD_EN
      check("haz_spacing", r1.cyc - r0.cyc, 32'd1);
`else
      check("haz_spacing", r1.cyc - r0.cyc, 32'd2);
`endif

      // Same-index decrement pair: second must see the first's result (2 -> 1 -> 0).
      push(4'd9, 1'b0); push(4'd9, 1'b0);
      wait_obs("haz_dn_count", 2, 20);
      expect_write("haz_dn0", 4'd9, 2'd1);
      expect_write("haz_dn1", 4'd9, 2'd0);

      // Overflow: 6 pushes during the sweep, only 4 fit.
      flush();
      check("ovf_flush_busy", 32'(bus.init_busy), 32'd1);
      check("ovf_flush_idx", 32'(bus.pht_wr_index), 32'd0);
      for (int k = 0; k < 6; k++) begin
         check("ovf_ready", 32'(bus.upd_ready), (k < 4) ? 32'd1 : 32'd0);
         push(W'(k + 1), 1'b1);
      end
      check("ovf_flag", 32'(bus.overflow), 32'd1);
      wait_obs("ovf_drain_count", 4, 40);
      expect_write("ovf_w0", 4'd1, 2'd3);
      expect_write("ovf_w1", 4'd2, 2'd3);
      expect_write("ovf_w2", 4'd3, 2'd3);
      expect_write("ovf_w3", 4'd4, 2'd3);
      for (int i = 0; i < 6; i++) step();
      check("ovf_no_extra", 32'(obs_q.size()), 32'd0);
      check("ovf_sticky", 32'(bus.overflow), 32'd1);

      // Flush with 3 queued updates plus a same-cycle push.
      flush();
      push(4'd10, 1'b1); push(4'd11, 1'b1); push(4'd12, 1'b0);
      step(); step(); step();
      check("fl_pre_idx", 32'(bus.pht_wr_index), 32'd6);
      check("fl_pre_head", 32'(bus.pht_rd_index), 32'd10);
      bus.flush_req = 1'b1;
      bus.upd_valid = 1'b1;
      bus.upd_index = 4'd13;
      bus.upd_taken = 1'b1;
      step();
      bus.flush_req = 1'b0;
      bus.upd_valid = 1'b0;
      check("fl_idx_restart", 32'(bus.pht_wr_index), 32'd0);
      check("fl_busy", 32'(bus.init_busy), 32'd1);
      check("fl_head_empty", 32'(bus.pht_rd_index), 32'd0);
      check("fl_ready", 32'(bus.upd_ready), 32'd1);
      for (int i = 0; i < 24; i++) step();
      check("fl_run_again", 32'(bus.init_busy), 32'd0);
      check("fl_no_writes", 32'(obs_q.size()), 32'd0);

      // Asynchronous reset in the middle of a sweep.
      flush();
      step(); step(); step(); step();
      check("ar_pre_idx", 32'(bus.pht_wr_index), 32'd4);
      #2;
      rst = 1'b1;
      #1;
      check("ar_idx", 32'(bus.pht_wr_index), 32'd0);
      check("ar_busy", 32'(bus.init_busy), 32'd1);
      check("ar_ovf_clr", 32'(bus.overflow), 32'd0);
      step();
      rst = 1'b0;
      for (int i = 0; i < 20; i++) step();
      check("ar_swept", 32'(bus.init_busy), 32'd0);

      // Asynchronous reset with an update queued: it is lost.
      push(4'd2, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check("ru_busy", 32'(bus.init_busy), 32'd1);
      check("ru_we", 32'(bus.pht_we), 32'd1);
      check("ru_data", 32'(bus.pht_wr_data), 32'd2);
      check("ru_ready", 32'(bus.upd_ready), 32'd1);
      step();
      rst = 1'b0;
      for (int i = 0; i < 24; i++) step();
      check("ru_lost", 32'(obs_q.size()), 32'd0);
      check("ru_mem2", 32'(pht_mem[2]), 32'd2);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end
endmodule
